// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: widths, source priority order and the
// buffered result entry.
package wb_pkg;

  localparam int PW   = 6;
  localparam int DW   = 32;
  localparam int NSRC = 4;

  // Incoming sources in retirement priority order.
  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_SFU = 2'd1,
    SRC_BRU = 2'd2,
    SRC_AGU = 2'd3
  } src_e;

  typedef struct packed {
    logic [PW-1:0] tag;
    logic [DW-1:0] data;
  } wb_entry_t;

  // Pointer advance modulo depth; inc never exceeds NSRC and depth >= NSRC,
  // so one conditional subtraction is enough.
  function automatic int wrap_add(input int ptr, input int inc, input int depth);
    int sum;
    sum = ptr + inc;
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Overflow buffer for writeback results: up to four enqueues and two dequeues
// per cycle, exposing the two oldest entries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            n_enq,
  input  wb_entry_t [NSRC-1:0]  enq_entries,
  input  logic [1:0]            n_deq,
  output logic [CW-1:0]         count,
  output wb_entry_t             head0,
  output wb_entry_t             head1
);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  assign count = count_q;
  assign head0 = mem_q[rd_ptr_q];
  assign head1 = mem_q[AW'(wrap_add(int'(rd_ptr_q), 1, DEPTH))];

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NSRC; i++) begin
      if (i < int'(n_enq)) begin
        mem_d[AW'(wrap_add(int'(wr_ptr_q), i, DEPTH))] = enq_entries[i];
      end
    end
    wr_ptr_d = AW'(wrap_add(int'(wr_ptr_q), int'(n_enq), DEPTH));
    rd_ptr_d = AW'(wrap_add(int'(rd_ptr_q), int'(n_deq), DEPTH));
    count_d  = count_q + CW'(n_enq) - CW'(n_deq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires up to four result bundles per cycle through two
// regfile/wakeup ports, buffers the overflow and resolves branches.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] aluoutw,
  input  logic [PW-1:0] alurdw,
  input  logic          aluenw,
  input  logic [DW-1:0] sfuoutw,
  input  logic [PW-1:0] sfurdw,
  input  logic          sfuenw,
  input  logic [DW-1:0] aguoutw,
  input  logic [PW-1:0] agurdw,
  input  logic          aguenw,
  input  logic [DW-1:0] brulinkw,
  input  logic [PW-1:0] brurdw,
  input  logic          bruenw,
  input  logic          pre_rightw,
  input  logic          b_typew,
  input  logic          real_directionw,
  input  logic [DW-1:0] addrw,
  output logic          we0,
  output logic [PW-1:0] waddr0,
  output logic [DW-1:0] wdata0,
  output logic          we1,
  output logic [PW-1:0] waddr1,
  output logic [DW-1:0] wdata1,
  output logic          stall,
  output logic          recover,
  output logic [DW-1:0] redirect_pc,
  output logic          bp_upd,
  output logic          bp_taken
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]        count;
  wb_entry_t            head0, head1;
  wb_entry_t            in_entry [NSRC];
  logic [NSRC-1:0]      in_en;
  logic [NSRC-1:0]      in_live;
  wb_entry_t [NSRC-1:0] enq_entries;
  logic [2:0]           n_enq;
  logic [1:0]           n_deq;
  logic [2:0]           n_port;
  logic                 accept;
  logic                 bru_acc;

  logic          recover_q, recover_d;
  logic [DW-1:0] redirect_pc_q, redirect_pc_d;
  logic          bp_upd_q, bp_upd_d;
  logic          bp_taken_q, bp_taken_d;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .n_enq       (n_enq),
    .enq_entries (enq_entries),
    .n_deq       (n_deq),
    .count       (count),
    .head0       (head0),
    .head1       (head1)
  );

  // Threshold leaves room for a full four-wide bundle minus two writes.
  assign stall  = (count >= CW'(DEPTH - 2));
  assign accept = ~stall;

  always_comb begin
    in_entry[SRC_ALU] = {alurdw, aluoutw};
    in_entry[SRC_SFU] = {sfurdw, sfuoutw};
    in_entry[SRC_BRU] = {brurdw, brulinkw};
    in_entry[SRC_AGU] = {agurdw, aguoutw};
    in_en = {aguenw, bruenw, sfuenw, aluenw};
    in_live = '0;
    for (int i = 0; i < NSRC; i++) begin
      in_live[i] = accept & in_en[i] & (in_entry[i].tag != '0);
    end
  end

  // Buffered entries are older, so they claim the ports before new results.
  always_comb begin
    we0         = 1'b0;
    waddr0      = '0;
    wdata0      = '0;
    we1         = 1'b0;
    waddr1      = '0;
    wdata1      = '0;
    n_enq       = '0;
    enq_entries = '0;
    n_deq       = (count >= CW'(2)) ? 2'd2 : count[1:0];
    n_port      = {1'b0, n_deq};
    if (n_deq != 2'd0) begin
      we0    = 1'b1;
      waddr0 = head0.tag;
      wdata0 = head0.data;
    end
    if (n_deq == 2'd2) begin
      we1    = 1'b1;
      waddr1 = head1.tag;
      wdata1 = head1.data;
    end
    for (int i = 0; i < NSRC; i++) begin
      if (in_live[i]) begin
        if (n_port == 3'd0) begin
          we0    = 1'b1;
          waddr0 = in_entry[i].tag;
          wdata0 = in_entry[i].data;
        end else if (n_port == 3'd1) begin
          we1    = 1'b1;
          waddr1 = in_entry[i].tag;
          wdata1 = in_entry[i].data;
        end else begin
          enq_entries[n_enq[1:0]] = in_entry[i];
          n_enq = n_enq + 3'd1;
        end
        n_port = n_port + 3'd1;
      end
    end
  end

  always_comb begin
    bru_acc       = accept & bruenw;
    recover_d     = bru_acc & ~pre_rightw;
    redirect_pc_d = recover_d ? addrw : '0;
    bp_upd_d      = bru_acc & b_typew;
    bp_taken_d    = bru_acc & b_typew & real_directionw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      recover_q     <= 1'b0;
      redirect_pc_q <= '0;
      bp_upd_q      <= 1'b0;
      bp_taken_q    <= 1'b0;
    end else begin
      recover_q     <= recover_d;
      redirect_pc_q <= redirect_pc_d;
      bp_upd_q      <= bp_upd_d;
      bp_taken_q    <= bp_taken_d;
    end
  end

  assign recover     = recover_q;
  assign redirect_pc = redirect_pc_q;
  assign bp_upd      = bp_upd_q;
  assign bp_taken    = bp_taken_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, reset-in-traffic sequence and
// randomized traffic against a queue-based reference model.
module tb_wb_stage;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int NV    = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   aluoutw, sfuoutw, aguoutw, brulinkw, addrw;
  logic [5:0]    alurdw, sfurdw, agurdw, brurdw;
  logic          aluenw, sfuenw, aguenw, bruenw;
  logic          pre_rightw, b_typew, real_directionw;
  logic          we0, we1, stall, recover, bp_upd, bp_taken;
  logic [5:0]    waddr0, waddr1;
  logic [31:0]   wdata0, wdata1, redirect_pc;

  always #5 clk = ~clk;

  wb_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .aluoutw(aluoutw), .alurdw(alurdw), .aluenw(aluenw),
    .sfuoutw(sfuoutw), .sfurdw(sfurdw), .sfuenw(sfuenw),
    .aguoutw(aguoutw), .agurdw(agurdw), .aguenw(aguenw),
    .brulinkw(brulinkw), .brurdw(brurdw), .bruenw(bruenw),
    .pre_rightw(pre_rightw), .b_typew(b_typew), .real_directionw(real_directionw),
    .addrw(addrw),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .stall(stall), .recover(recover), .redirect_pc(redirect_pc),
    .bp_upd(bp_upd), .bp_taken(bp_taken)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dat(input logic [5:0] t);
    return 32'hA0 + {26'd0, t};
  endfunction

  // Reference model: results waiting for a port, oldest first.
  wb_entry_t   mq[$];
  logic        m_rec = 1'b0, m_upd = 1'b0, m_taken = 1'b0, m_stl = 1'b0;
  logic [31:0] m_pc = '0;

  task automatic model_cycle(input bit do_chk);
    wb_entry_t        all[$];
    logic [3:0]       en;
    logic [3:0][5:0]  tg;
    logic [3:0][31:0] dt;
    logic             stl;
    int               nw;
    en  = {aguenw, bruenw, sfuenw, aluenw};
    tg  = {agurdw, brurdw, sfurdw, alurdw};
    dt  = {aguoutw, brulinkw, sfuoutw, aluoutw};
    stl = (mq.size() >= DEPTH - 2);
    all = mq;
    if (!stl) begin
      for (int i = 0; i < 4; i++) begin
        if (en[i] && tg[i] != 6'd0) all.push_back({tg[i], dt[i]});
      end
    end
    if (do_chk) begin
      chk("m_stall", 32'(stall), 32'(stl));
      chk("m_we0", 32'(we0), 32'(all.size() > 0));
      chk("m_we1", 32'(we1), 32'(all.size() > 1));
      if (all.size() > 0) begin
        chk("m_waddr0", 32'(waddr0), 32'(all[0].tag));
        chk("m_wdata0", wdata0, all[0].data);
      end
      if (all.size() > 1) begin
        chk("m_waddr1", 32'(waddr1), 32'(all[1].tag));
        chk("m_wdata1", wdata1, all[1].data);
      end
      chk("m_recover", 32'(recover), 32'(m_rec));
      if (m_rec) chk("m_redirect_pc", redirect_pc, m_pc);
      chk("m_bp_upd", 32'(bp_upd), 32'(m_upd));
      if (m_upd) chk("m_bp_taken", 32'(bp_taken), 32'(m_taken));
      checks++;
      if (we1 && !we0) begin
        failures++;
        $display("FAIL port_order: we0=%0b we1=%0b required we0=1 when we1=1", we0, we1);
      end
      checks++;
      if (we0 && we1 && waddr0 == waddr1) begin
        failures++;
        $display("FAIL port_tags: waddr0=%0d waddr1=%0d required distinct", waddr0, waddr1);
      end
    end
    m_stl = stl;
    if (rst) begin
      mq.delete();
      m_rec = 1'b0; m_upd = 1'b0; m_taken = 1'b0; m_pc = '0;
    end else begin
      nw = (all.size() > 2) ? 2 : all.size();
      for (int k = 0; k < nw; k++) void'(all.pop_front());
      mq = all;
      if (mq.size() > DEPTH) begin
        failures++;
        $display("FAIL overflow: occupancy %0d required <= %0d", mq.size(), DEPTH);
      end
      m_rec   = !stl && bruenw && !pre_rightw;
      m_pc    = addrw;
      m_upd   = !stl && bruenw && b_typew;
      m_taken = real_directionw;
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] en, input logic [3:0][5:0] tg,
                       input logic [3:0][31:0] dt, input logic pr, input logic bt,
                       input logic rd, input logic [31:0] ad);
    @(negedge clk);
    rst = r;
    aluenw = en[0]; alurdw = tg[0]; aluoutw  = dt[0];
    sfuenw = en[1]; sfurdw = tg[1]; sfuoutw  = dt[1];
    bruenw = en[2]; brurdw = tg[2]; brulinkw = dt[2];
    aguenw = en[3]; agurdw = tg[3]; aguoutw  = dt[3];
    pre_rightw = pr; b_typew = bt; real_directionw = rd; addrw = ad;
    #1;
  endtask

  task automatic drive_idle(input logic r);
    drive(r, 4'b0000, '0, '0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  typedef struct {
    logic [3:0]      en;
    logic [3:0][5:0] tg;
    logic            pr, bt, rd;
    logic [31:0]     ad;
    logic            e_stall, e_we0;
    logic [5:0]      e_a0;
    logic            e_we1;
    logic [5:0]      e_a1;
    logic            e_rec;
    logic [31:0]     e_pc;
    logic            e_upd, e_taken;
  } vec_t;

  function automatic vec_t mkv(input logic [3:0] en, input logic [5:0] ta, input logic [5:0] ts,
                               input logic [5:0] tb, input logic [5:0] tg, input logic pr,
                               input logic bt, input logic rd, input logic [31:0] ad,
                               input logic e_stall, input logic e_we0, input logic [5:0] e_a0,
                               input logic e_we1, input logic [5:0] e_a1, input logic e_rec,
                               input logic [31:0] e_pc, input logic e_upd, input logic e_taken);
    vec_t v;
    v.en = en; v.tg = {tg, tb, ts, ta};
    v.pr = pr; v.bt = bt; v.rd = rd; v.ad = ad;
    v.e_stall = e_stall; v.e_we0 = e_we0; v.e_a0 = e_a0; v.e_we1 = e_we1; v.e_a1 = e_a1;
    v.e_rec = e_rec; v.e_pc = e_pc; v.e_upd = e_upd; v.e_taken = e_taken;
    return v;
  endfunction

  vec_t tbl [NV];

  initial begin
    logic [3:0][31:0] dts;
    logic [3:0]       r_en;
    logic [3:0][5:0]  r_tg;
    logic [3:0][31:0] r_dt;
    logic             r_pr, r_bt, r_rd, r_rst;
    logic [31:0]      r_ad;
    bit               repres;
    bit               used [64];
    int               t;

    rst = 1'b1;
    aluenw = 0; sfuenw = 0; aguenw = 0; bruenw = 0;
    alurdw = 0; sfurdw = 0; agurdw = 0; brurdw = 0;
    aluoutw = 0; sfuoutw = 0; aguoutw = 0; brulinkw = 0;
    pre_rightw = 1; b_typew = 0; real_directionw = 0; addrw = 0;

    //            en       alu sfu bru agu pr bt rd addr        stl we0 a0 we1 a1 rec pc        upd tkn
    tbl[0]  = mkv(4'b0001,  5,  0,  0,  0, 1, 0, 0, 32'h0,      0,  1,  5, 0,  0, 0,  32'h0,    0,  0);
    tbl[1]  = mkv(4'b0000,  0,  0,  0,  0, 1, 0, 0, 32'h0,      0,  0,  0, 0,  0, 0,  32'h0,    0,  0);
    tbl[2]  = mkv(4'b1111,  1,  2,  3,  4, 1, 0, 0, 32'h0,      0,  1,  1, 1,  2, 0,  32'h0,    0,  0);
    tbl[3]  = mkv(4'b1111,  1,  2,  3,  4, 1, 0, 0, 32'h0,      1,  1,  3, 1,  4, 0,  32'h0,    0,  0);
    tbl[4]  = mkv(4'b0000,  0,  0,  0,  0, 1, 0, 0, 32'h0,      0,  0,  0, 0,  0, 0,  32'h0,    0,  0);
    tbl[5]  = mkv(4'b0011,  0,  7,  0,  0, 1, 0, 0, 32'h0,      0,  1,  7, 0,  0, 0,  32'h0,    0,  0);
    tbl[6]  = mkv(4'b0000,  0,  0,  0,  0, 1, 0, 0, 32'h0,      0,  0,  0, 0,  0, 0,  32'h0,    0,  0);
    tbl[7]  = mkv(4'b0100,  0,  0,  9,  0, 0, 1, 1, 32'h1000,   0,  1,  9, 0,  0, 0,  32'h0,    0,  0);
    tbl[8]  = mkv(4'b0000,  0,  0,  0,  0, 1, 0, 0, 32'h0,      0,  0,  0, 0,  0, 1,  32'h1000, 1,  1);
    tbl[9]  = mkv(4'b0000,  0,  0,  0,  0, 1, 0, 0, 32'h0,      0,  0,  0, 0,  0, 0,  32'h0,    0,  0);
    tbl[10] = mkv(4'b1111, 10, 11, 12, 13, 1, 0, 0, 32'h0,      0,  1, 10, 1, 11, 0,  32'h0,    0,  0);
    tbl[11] = mkv(4'b0100,  0,  0, 20,  0, 0, 1, 0, 32'h2000,   1,  1, 12, 1, 13, 0,  32'h0,    0,  0);
    tbl[12] = mkv(4'b0100,  0,  0, 20,  0, 0, 1, 0, 32'h2000,   0,  1, 20, 0,  0, 0,  32'h0,    0,  0);
    tbl[13] = mkv(4'b0000,  0,  0,  0,  0, 1, 0, 0, 32'h0,      0,  0,  0, 0,  0, 1,  32'h2000, 1,  0);
    tbl[14] = mkv(4'b0000,  0,  0,  0,  0, 1, 0, 0, 32'h0,      0,  0,  0, 0,  0, 0,  32'h0,    0,  0);

    drive_idle(1'b1); model_cycle(1'b0);
    drive_idle(1'b1); model_cycle(1'b0);

    for (int i = 0; i < NV; i++) begin
      for (int s = 0; s < 4; s++) dts[s] = dat(tbl[i].tg[s]);
      drive(1'b0, tbl[i].en, tbl[i].tg, dts, tbl[i].pr, tbl[i].bt, tbl[i].rd, tbl[i].ad);
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_we0", i), 32'(we0), 32'(tbl[i].e_we0));
      if (tbl[i].e_we0) begin
        chk($sformatf("v%0d_waddr0", i), 32'(waddr0), 32'(tbl[i].e_a0));
        chk($sformatf("v%0d_wdata0", i), wdata0, dat(tbl[i].e_a0));
      end
      chk($sformatf("v%0d_we1", i), 32'(we1), 32'(tbl[i].e_we1));
      if (tbl[i].e_we1) begin
        chk($sformatf("v%0d_waddr1", i), 32'(waddr1), 32'(tbl[i].e_a1));
        chk($sformatf("v%0d_wdata1", i), wdata1, dat(tbl[i].e_a1));
      end
      chk($sformatf("v%0d_recover", i), 32'(recover), 32'(tbl[i].e_rec));
      if (tbl[i].e_rec) chk($sformatf("v%0d_redirect_pc", i), redirect_pc, tbl[i].e_pc);
      chk($sformatf("v%0d_bp_upd", i), 32'(bp_upd), 32'(tbl[i].e_upd));
      if (tbl[i].e_upd) chk($sformatf("v%0d_bp_taken", i), 32'(bp_taken), 32'(tbl[i].e_taken));
      model_cycle(1'b1);
    end

    // Build occupancy 3 with a pending mispredict, then reset on top of it.
    for (int s = 0; s < 4; s++) dts[s] = dat(6'(s + 1));
    drive(1'b0, 4'b0111, {6'd0, 6'd3, 6'd2, 6'd1}, dts, 1'b1, 1'b0, 1'b0, 32'h0);
    model_cycle(1'b1);
    for (int s = 0; s < 4; s++) dts[s] = dat(6'(s + 4));
    drive(1'b0, 4'b1111, {6'd7, 6'd6, 6'd5, 6'd4}, dts, 1'b0, 1'b1, 1'b1, 32'h3000);
    chk("rst_pre_stall", 32'(stall), 32'd0);
    chk("rst_pre_waddr0", 32'(waddr0), 32'd3);
    chk("rst_pre_waddr1", 32'(waddr1), 32'd4);
    model_cycle(1'b1);
    drive_idle(1'b1);
    chk("rst_cycle_stall", 32'(stall), 32'd1);
    chk("rst_cycle_recover", 32'(recover), 32'd1);
    model_cycle(1'b0);
    drive_idle(1'b0);
    chk("rst_after_stall", 32'(stall), 32'd0);
    chk("rst_after_we0", 32'(we0), 32'd0);
    chk("rst_after_we1", 32'(we1), 32'd0);
    chk("rst_after_recover", 32'(recover), 32'd0);
    chk("rst_after_bp_upd", 32'(bp_upd), 32'd0);
    model_cycle(1'b1);

    // Random traffic; a stalled bundle is re-presented unchanged.
    repres = 1'b0;
    r_en = '0; r_tg = '0; r_dt = '0; r_pr = 1'b1; r_bt = 1'b0; r_rd = 1'b0; r_ad = '0;
    for (int c = 0; c < 400; c++) begin
      if (!repres) begin
        for (int k = 0; k < 64; k++) used[k] = 1'b0;
        foreach (mq[k]) used[mq[k].tag] = 1'b1;
        for (int s = 0; s < 4; s++) begin
          r_en[s] = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 7) == 0) begin
            r_tg[s] = 6'd0;
          end else begin
            do t = int'($urandom_range(1, 63)); while (used[t]);
            used[t] = 1'b1;
            r_tg[s] = 6'(t);
          end
          r_dt[s] = $urandom();
        end
        r_pr = m_rec ? 1'b1 : ($urandom_range(0, 2) != 0);
        r_bt = 1'($urandom_range(0, 1));
        r_rd = 1'($urandom_range(0, 1));
        r_ad = $urandom();
      end
      r_rst = ($urandom_range(0, 49) == 0);
      drive(r_rst, r_en, r_tg, r_dt, r_pr, r_bt, r_rd, r_ad);
      model_cycle(!r_rst);
      repres = m_stl && !r_rst;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
